// File: rtl/hazard_frame_sequencer.sv
// Buffers one frame of hazard boxes, then ORs each box's 4x8 cell occupancy
// mask into a 32-bit accumulator and hands the two 16-bit spike vectors out.
module hazard_frame_sequencer #(
  parameter int MAX_HAZARDS = 16,
  parameter int IMG_WIDTH   = 26,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_top,
  input  logic [4:0]  in_left,
  input  logic [4:0]  in_bottom,
  input  logic [4:0]  in_right,
  input  logic        frame_end,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] vec1,
  output logic [15:0] vec2,
  output logic [4:0]  num_hazards,
  output logic        overflow,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CELL_W = IMG_WIDTH / 8;
  localparam int CELL_H = IMG_HEIGHT / 4;

  // Handshake: a beat transfers on a rising edge where valid && ready are both
  // high; the producer holds its data stable while valid is high and ready low.
  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ENCODE  = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  logic [3:0]  idx_q;
  logic        ovf_flag_q;
  logic [31:0] acc_q;
  logic [19:0] box_q [MAX_HAZARDS];
  logic [15:0] vec1_q, vec2_q;
  logic [4:0]  num_q;
  logic        ovf_q, out_valid_q, in_ready_q, busy_q;
  logic [31:0] cur_mask;
  logic [31:0] acc_d;

  // Box packing is {top, left, bottom, right}; malformed boxes hit nothing.
  function automatic logic [31:0] box_mask(input logic [19:0] b);
    logic [4:0] t, l, bo, r;
    logic [4:0] ct, cb, cl, cr;
    logic [31:0] m;
    {t, l, bo, r} = b;
    m = '0;
    if ((l <= r) && (t <= bo)) begin
      for (int rr = 0; rr < 4; rr++) begin
        for (int cc = 0; cc < 8; cc++) begin
          ct = 5'(rr * CELL_H);
          cb = 5'(rr * CELL_H + CELL_H - 1);
          cl = 5'(cc * CELL_W);
          cr = 5'(cc * CELL_W + CELL_W - 1);
          m[rr*8+cc] = !((bo < ct) || (t > cb) || (r < cl) || (l > cr));
        end
      end
    end
    return m;
  endfunction

  assign cur_mask = box_mask(box_q[idx_q]);
  assign acc_d    = acc_q | cur_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      count_q     <= '0;
      idx_q       <= '0;
      ovf_flag_q  <= 1'b0;
      acc_q       <= '0;
      vec1_q      <= '0;
      vec2_q      <= '0;
      num_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (in_valid) begin
            if (count_q < 5'(MAX_HAZARDS)) begin
              box_q[count_q[3:0]] <= {in_top, in_left, in_bottom, in_right};
              count_q             <= count_q + 5'd1;
            end else begin
              ovf_flag_q <= 1'b1;
            end
          end
          if (frame_end) begin
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            // A box arriving alongside frame_end still counts, so an empty
            // frame means nothing stored and nothing accepted this cycle.
            if ((count_q == 5'd0) && !in_valid) begin
              state_q     <= S_OUTPUT;
              out_valid_q <= 1'b1;
              vec1_q      <= '0;
              vec2_q      <= '0;
              num_q       <= '0;
              ovf_q       <= ovf_flag_q;
            end else begin
              state_q <= S_ENCODE;
            end
          end
        end
        S_ENCODE: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 4'd1;
          if ({1'b0, idx_q} == (count_q - 5'd1)) begin
            state_q     <= S_OUTPUT;
            out_valid_q <= 1'b1;
            vec1_q      <= acc_d[15:0];
            vec2_q      <= acc_d[31:16];
            num_q       <= count_q;
            ovf_q       <= ovf_flag_q;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            state_q     <= S_COLLECT;
            count_q     <= '0;
            ovf_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_COLLECT;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign vec1        = vec1_q;
  assign vec2        = vec2_q;
  assign num_hazards = num_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/hazard_frame_sequencer.md
# hazard_frame_sequencer

Collects one frame's hazard bounding boxes from the detector as a valid/ready stream and buffers up to 16 of them. After the frame closes, it walks the buffer one box per cycle and accumulates the 32-cell occupancy mask (4 rows × 8 columns over the 26×8 image) into the two 16-bit spike vectors the SNN input stage consumes. It then presents the result on an output handshake. It is the sequential front end that replaces driving the combinational hazard encoder directly from unregistered detector outputs.

## Interface
- MAX_HAZARDS, 16 — box buffer depth; count saturates here.
- IMG_WIDTH, 26 — image width in pixels.
- IMG_HEIGHT, 8 — image height in pixels.
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  box beat valid.
- in_ready  out  1  sequencer accepts box beats.
- in_top, in_left, in_bottom, in_right  in  5 each  inclusive box coordinates, unsigned.
- frame_end  in  1  single-cycle pulse closing the current frame.
- out_valid  out  1  vec1/vec2/num_hazards/overflow valid.
- out_ready  in  1  consumer accepts result.
- vec1  out  16  cells 0–15 (rows 0–1).
- vec2  out  16  cells 16–31 (rows 2–3); bit k maps to cell 16+k.
- num_hazards  out  5  boxes stored this frame, 0–16.
- overflow  out  1  more than MAX_HAZARDS boxes were offered this frame.
- busy  out  1  high in ENCODE or OUTPUT.

## Operation
- **Cell geometry**
  - CELL_W = IMG_WIDTH/8 = 3 and CELL_H = IMG_HEIGHT/4 = 2, using integer division.
  - Cell n = row·8 + col covers x∈[3·col, 3·col+2] and y∈[2·row, 2·row+1].
  - Columns x = 24 and 25 belong to no cell.
- **Overlap rule**
  - A box hits a cell when none of the following hold: bottom<cell_top, top>cell_bottom, right<cell_left, left>cell_right.
  - All comparisons are unsigned, at 5 bits or wider.
- **Malformed boxes** (left>right or top>bottom)
  - They are stored and counted.
  - They contribute no cells.
- **COLLECT** (reset state)
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - While count<16, the box is written at index count and count increments.
  - Otherwise the box is dropped and overflow_flag is set to 1.
  - frame_end moves the state to ENCODE. A box accepted in the same cycle as frame_end is included.
  - On that transition, the accumulator is cleared and the index is set to 0.
  - If count=0, the state goes directly to OUTPUT.
- **ENCODE**
  - in_ready=0.
  - Each cycle, the accumulator is ORed with the 32-bit mask of box[index], and the index increments.
  - After index count−1 is processed, the state moves to OUTPUT.
  - frame_end is ignored in this state.
- **OUTPUT**
  - out_valid=1, vec1/vec2 = accumulator[15:0]/[31:16], num_hazards=count, overflow=overflow_flag.
  - All of these hold stable until out_valid && out_ready.
  - Then the state returns to COLLECT, and count and overflow_flag clear.
  - frame_end and in_valid are ignored in this state (in_ready=0).
- **Outputs**
  - All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.
  - vec1, vec2, num_hazards and overflow keep their last values outside OUTPUT.
  - Consumers must qualify them with out_valid.

## Timing
- **Reset** (rst_n low at a clock edge)
  - State=COLLECT, count=0, overflow_flag=0, accumulator=0.
  - vec1=vec2=0, num_hazards=0, overflow=0, out_valid=0, busy=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-ENCODE or mid-OUTPUT aborts the frame with no output; buffered boxes are discarded.
- Let frame_end be sampled at edge T with N stored boxes:
  - ENCODE occupies cycles T+1 … T+N.
  - out_valid rises at T+1+N.
  - For N=0, out_valid rises at T+1.
- The handshake completes at edge H. in_ready=1 and out_valid=0 from H+1.
- Back-pressure: out_ready may stay low indefinitely. The block holds OUTPUT and in_ready stays 0.
- Throughput: one box per cycle in COLLECT; one box per cycle in ENCODE.

## Test plan
- **Single box, cell 0:** box (t0, l0, b1, r2) then frame_end → out_valid 2 cycles after frame_end, vec1=0x0001, vec2=0x0000, num_hazards=1, overflow=0.
- **Corner cases:**
  - Box (t6, l21, b7, r25) → vec2=0x8000.
  - Box (t0, l24, b0, r25) → vec1=vec2=0.
  - Full box (t0, l0, b7, r25) → vec1=vec2=0xFFFF.
- **Overflow:** 18 boxes, where boxes 0–15 are (t0, l0, b0, r0) and boxes 16–17 are (t7, l0, b7, r25) → num_hazards=16, overflow=1, vec1=0x0001, vec2=0x0000. The next frame reports overflow=0.
- **Empty frame and malformed box:**
  - frame_end with no boxes → out_valid the next cycle, all-zero vectors, num_hazards=0.
  - Frame with box (t0, l5, b1, r3) → num_hazards=1, vectors zero.
- **Back-pressure and simultaneity:**
  - Box accepted in the same cycle as frame_end is included.
  - out_ready held low 5 cycles → outputs stable, in_ready=0, in_valid ignored.
  - Handshake → in_ready=1 the next cycle.
- **Reset mid-ENCODE:** with 8 boxes, assert rst_n=0 on the 3rd ENCODE cycle → next cycle out_valid=0, in_ready=1 once rst_n deasserts, all outputs zero. A following 1-box frame encodes correctly.
